nios2os_st_pkt_fifo: RTL and testbench

//   Show-ahead Avalon-ST packet FIFO on the 32-bit stream output of the error adapter.

---
 rtl/nios2os_st_pkt_fifo.sv | 200 ++++++++++++++++++++
 tb/tb_nios2os_st_pkt_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2os_st_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : nios2os_st_pkt_fifo
// Description : Show-ahead 32-bit Avalon-ST packet FIFO with SOP/EOP framing
//               checker and packet status counters.
// Revision    : 1.0 - initial release
// ============================================================================
module nios2os_st_pkt_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              reset,

    output logic              o_in_ready,
    input  logic              i_in_valid,
    input  logic [31:0]       i_in_data,
    input  logic              i_in_startofpacket,
    input  logic              i_in_endofpacket,
    input  logic [1:0]        i_in_empty,

    input  logic              i_out_ready,
    output logic              o_out_valid,
    output logic [31:0]       o_out_data,
    output logic              o_out_startofpacket,
    output logic              o_out_endofpacket,
    output logic [1:0]        o_out_empty,

    output logic [AW:0]       o_fill_level,
    output logic [15:0]       o_pkt_count,
    output logic [LEN_W-1:0]  o_last_pkt_bytes,
    output logic              o_framing_err,
    input  logic              i_clear_status
);

    localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_IN_PKT = 1'b1
    } t_rx_state;

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    logic [35:0]       r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_in_ready;

    logic              w_wr;
    logic              w_rd;
    logic [AW:0]       w_count_nxt;
    logic [35:0]       w_head;

    assign w_wr = i_in_valid & r_in_ready;
    assign w_rd = (r_count != '0) & i_out_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // in_ready is a registered copy of "not full" so it never depends
    // combinationally on out_ready; a read of a full FIFO frees space next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != c_FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {i_in_startofpacket, i_in_endofpacket,
                                i_in_empty, i_in_data};
        end
    end

    assign w_head              = r_mem[r_rd_ptr];
    assign o_out_valid         = (r_count != '0);
    assign o_out_startofpacket = w_head[35];
    assign o_out_endofpacket   = w_head[34];
    assign o_out_empty         = w_head[33:32];
    assign o_out_data          = w_head[31:0];
    assign o_fill_level        = r_count;
    assign o_in_ready          = r_in_ready;

    // ------------------------------------------------------------------
    // Rx framing FSM (accepted beats only)
    // ------------------------------------------------------------------
    t_rx_state         r_state;
    t_rx_state         w_state_nxt;
    logic              w_restart;
    logic              w_violation;
    logic              w_pkt_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_violation = 1'b0;
        w_pkt_done  = 1'b0;
        if (w_wr) begin
            w_pkt_done = i_in_endofpacket;
            case (r_state)
                S_IDLE: begin
                    // A missing SOP is flagged but the beat still opens a packet.
                    w_restart   = 1'b1;
                    w_violation = ~i_in_startofpacket;
                end
                S_IN_PKT: begin
                    w_restart   = i_in_startofpacket;
                    w_violation = i_in_startofpacket;
                end
                default: begin
                    w_restart = 1'b1;
                end
            endcase
            w_state_nxt = i_in_endofpacket ? S_IDLE : S_IN_PKT;
        end
    end

    // ------------------------------------------------------------------
    // Byte accumulator and status
    // ------------------------------------------------------------------
    logic [LEN_W-1:0]  r_acc;
    logic [15:0]       r_pkt_count;
    logic [LEN_W-1:0]  r_last_bytes;
    logic              r_framing_err;

    logic [2:0]        w_beat_bytes;
    logic [LEN_W-1:0]  w_base;
    logic [LEN_W:0]    w_sum;
    logic [LEN_W-1:0]  w_acc_sat;

    assign w_beat_bytes = i_in_endofpacket ? (3'd4 - {1'b0, i_in_empty}) : 3'd4;
    assign w_base       = w_restart ? '0 : r_acc;
    assign w_sum        = {1'b0, w_base} + (LEN_W+1)'(w_beat_bytes);
    assign w_acc_sat    = w_sum[LEN_W] ? {LEN_W{1'b1}} : w_sum[LEN_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_wr) begin
            r_acc <= w_pkt_done ? '0 : w_acc_sat;
        end
    end

    // clear_status takes priority over any update landing in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_count   <= '0;
            r_last_bytes  <= '0;
            r_framing_err <= 1'b0;
        end else if (i_clear_status) begin
            r_pkt_count   <= '0;
            r_last_bytes  <= '0;
            r_framing_err <= 1'b0;
        end else begin
            if (w_pkt_done) begin
                r_pkt_count  <= r_pkt_count + 1'b1;
                r_last_bytes <= w_acc_sat;
            end
            if (w_violation) begin
                r_framing_err <= 1'b1;
            end
        end
    end

    assign o_pkt_count      = r_pkt_count;
    assign o_last_pkt_bytes = r_last_bytes;
    assign o_framing_err    = r_framing_err;

endmodule
`default_nettype wire

// File: tb/tb_nios2os_st_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios2os_st_pkt_fifo
// Description : Self-checking bench: queue-based reference model plus
//               directed packet scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2os_st_pkt_fifo;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic        o_in_ready;
    logic        i_in_valid;
    logic [31:0] i_in_data;
    logic        i_in_startofpacket;
    logic        i_in_endofpacket;
    logic [1:0]  i_in_empty;
    logic        i_out_ready;
    logic        o_out_valid;
    logic [31:0] o_out_data;
    logic        o_out_startofpacket;
    logic        o_out_endofpacket;
    logic [1:0]  o_out_empty;
    logic [4:0]  o_fill_level;
    logic [15:0] o_pkt_count;
    logic [15:0] o_last_pkt_bytes;
    logic        o_framing_err;
    logic        i_clear_status;

    int n_checks = 0;
    int n_errors = 0;

    nios2os_st_pkt_fifo #(.DEPTH(16), .AW(4), .LEN_W(16)) dut (
        .clk                 (clk),
        .reset               (reset),
        .o_in_ready          (o_in_ready),
        .i_in_valid          (i_in_valid),
        .i_in_data           (i_in_data),
        .i_in_startofpacket  (i_in_startofpacket),
        .i_in_endofpacket    (i_in_endofpacket),
        .i_in_empty          (i_in_empty),
        .i_out_ready         (i_out_ready),
        .o_out_valid         (o_out_valid),
        .o_out_data          (o_out_data),
        .o_out_startofpacket (o_out_startofpacket),
        .o_out_endofpacket   (o_out_endofpacket),
        .o_out_empty         (o_out_empty),
        .o_fill_level        (o_fill_level),
        .o_pkt_count         (o_pkt_count),
        .o_last_pkt_bytes    (o_last_pkt_bytes),
        .o_framing_err       (o_framing_err),
        .i_clear_status      (i_clear_status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of beats plus packet bookkeeping
    // ------------------------------------------------------------------
    logic [35:0] m_q[$];
    bit          m_in_rdy;
    bit          m_in_pkt;
    int          m_acc;
    logic [15:0] m_cnt;
    logic [15:0] m_last;
    bit          m_err;

    task automatic model_clear();
        m_q.delete();
        m_in_rdy = 0;
        m_in_pkt = 0;
        m_acc    = 0;
        m_cnt    = '0;
        m_last   = '0;
        m_err    = 0;
    endtask

    task automatic model_step();
        bit wr, rd;
        wr = i_in_valid && m_in_rdy;
        rd = (m_q.size() != 0) && i_out_ready;
        if (wr) begin
            if (!m_in_pkt || i_in_startofpacket) begin
                if (m_in_pkt == i_in_startofpacket) m_err = 1;
                m_acc = 0;
            end
            m_acc += i_in_endofpacket ? (4 - int'(i_in_empty)) : 4;
            if (m_acc > 65535) m_acc = 65535;
            if (i_in_endofpacket) begin
                m_last   = 16'(m_acc);
                m_cnt    = m_cnt + 16'd1;
                m_acc    = 0;
                m_in_pkt = 0;
            end else begin
                m_in_pkt = 1;
            end
        end
        if (i_clear_status) begin
            m_cnt  = '0;
            m_last = '0;
            m_err  = 0;
        end
        if (rd) void'(m_q.pop_front());
        if (wr) m_q.push_back({i_in_startofpacket, i_in_endofpacket, i_in_empty, i_in_data});
        m_in_rdy = (m_q.size() != DEPTH);
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else       model_step();
        end
    end

    always @(negedge clk) begin
        chk("out_valid", 64'(o_out_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0)
            chk("out_beat", 64'({o_out_startofpacket, o_out_endofpacket, o_out_empty, o_out_data}),
                64'(m_q[0]));
        chk("fill_level", 64'(o_fill_level), 64'(m_q.size()));
        chk("in_ready", 64'(o_in_ready), 64'(m_in_rdy));
        chk("pkt_count", 64'(o_pkt_count), 64'(m_cnt));
        chk("last_pkt_bytes", 64'(o_last_pkt_bytes), 64'(m_last));
        chk("framing_err", 64'(o_framing_err), 64'(m_err));
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic sop, input logic eop, input logic [1:0] emp, input logic [31:0] d);
        i_in_valid         = 1'b1;
        i_in_startofpacket = sop;
        i_in_endofpacket   = eop;
        i_in_empty         = emp;
        i_in_data          = d;
        step();
        i_in_valid         = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        i_in_valid         = 1'b0;
        i_in_data          = '0;
        i_in_startofpacket = 1'b0;
        i_in_endofpacket   = 1'b0;
        i_in_empty         = '0;
        i_out_ready        = 1'b0;
        i_clear_status     = 1'b0;
        step();
        step();
        chk("rst_in_ready", 64'(o_in_ready), 64'd0);
        chk("rst_out_valid", 64'(o_out_valid), 64'd0);
        chk("rst_fill", 64'(o_fill_level), 64'd0);
        reset = 1'b0;
        step();
        chk("ready_after_rst", 64'(o_in_ready), 64'd1);

        // 3-beat packet, empty=2 on EOP: 4+4+2 bytes
        i_out_ready = 1'b1;
        beat(1, 0, 0, 32'hA000_0001);
        beat(0, 0, 0, 32'hA000_0002);
        beat(0, 1, 2, 32'hA000_0003);
        chk("t1_pkt_count", 64'(o_pkt_count), 64'd1);
        chk("t1_last_bytes", 64'(o_last_pkt_bytes), 64'd10);
        repeat (3) step();

        // Stream 20 beats into a stalled FIFO; only 16 fit
        i_out_ready = 1'b0;
        for (int i = 0; i < 20; i++) beat(i == 0, 0, 0, 32'hB000_0000 + i);
        chk("t2_fill_full", 64'(o_fill_level), 64'd16);
        chk("t2_ready_low", 64'(o_in_ready), 64'd0);

        // Read and write together while full: write refused, then refills
        i_out_ready = 1'b1;
        beat(0, 0, 0, 32'hC000_0000);
        chk("t3_fill_15", 64'(o_fill_level), 64'd15);
        chk("t3_ready_back", 64'(o_in_ready), 64'd1);
        i_out_ready = 1'b0;
        beat(0, 0, 0, 32'hC000_0000);
        chk("t3_refill", 64'(o_fill_level), 64'd16);

        i_out_ready = 1'b1;
        repeat (20) step();
        chk("t2_drained", 64'(o_fill_level), 64'd0);
        chk("t2_ready_after", 64'(o_in_ready), 64'd1);
        beat(0, 1, 0, 32'hC000_0001);
        chk("t2_last_bytes", 64'(o_last_pkt_bytes), 64'd72);
        chk("t2_pkt_count", 64'(o_pkt_count), 64'd2);
        chk("t2_no_err", 64'(o_framing_err), 64'd0);

        // Second SOP before EOP restarts the byte count
        beat(1, 0, 0, 32'hD000_0001);
        beat(0, 0, 0, 32'hD000_0002);
        beat(1, 0, 0, 32'hD000_0003);
        chk("t4_err", 64'(o_framing_err), 64'd1);
        beat(0, 0, 0, 32'hD000_0004);
        beat(0, 1, 1, 32'hD000_0005);
        chk("t4_last_bytes", 64'(o_last_pkt_bytes), 64'd11);
        chk("t4_pkt_count", 64'(o_pkt_count), 64'd3);
        repeat (2) step();

        // Reset with 5 beats stored mid-packet
        i_out_ready = 1'b0;
        beat(1, 0, 0, 32'hE000_0000);
        for (int i = 1; i < 5; i++) beat(0, 0, 0, 32'hE000_0000 + i);
        chk("t5_fill_5", 64'(o_fill_level), 64'd5);
        reset = 1'b1;
        #1;
        chk("t5_out_valid", 64'(o_out_valid), 64'd0);
        chk("t5_fill_0", 64'(o_fill_level), 64'd0);
        chk("t5_status", 64'({o_pkt_count, o_last_pkt_bytes, o_framing_err}), 64'd0);
        step();
        reset = 1'b0;
        step();
        i_out_ready = 1'b1;
        beat(0, 0, 0, 32'hE100_0000);
        chk("t5_nosop_err", 64'(o_framing_err), 64'd1);
        beat(0, 1, 0, 32'hE100_0001);
        chk("t5_last_bytes", 64'(o_last_pkt_bytes), 64'd8);
        chk("t5_pkt_count", 64'(o_pkt_count), 64'd1);

        // Single-beat packet, then clear coincident with EOP
        beat(1, 1, 3, 32'hF000_0001);
        chk("t6_last_bytes", 64'(o_last_pkt_bytes), 64'd1);
        chk("t6_pkt_count", 64'(o_pkt_count), 64'd2);
        i_clear_status = 1'b1;
        beat(1, 1, 3, 32'hF000_0002);
        i_clear_status = 1'b0;
        chk("t6_cleared", 64'({o_pkt_count, o_last_pkt_bytes, o_framing_err}), 64'd0);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
